// File: rtl/simple_axi_pkg.sv
// AXI response/size/burst constants, FSM state types and request helpers shared by
// simple_axi_master and simple_axi_ram_slave.
package simple_axi_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   localparam logic [2:0] SIZE_BYTE  = 3'd0;
   localparam logic [2:0] SIZE_HALF  = 3'd1;
   localparam logic [2:0] SIZE_WORD  = 3'd2;
   localparam logic [2:0] SIZE_DWORD = 3'd3;

   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

   // Natural alignment of the low address bits for a given transfer size.
   function automatic logic addr_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
      case (size)
         SIZE_BYTE:  return 1'b1;
         SIZE_HALF:  return (addr_lo[0] == 1'b0);
         SIZE_WORD:  return (addr_lo[1:0] == 2'b00);
         SIZE_DWORD: return (addr_lo == 3'b000);
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] size_mask(input logic [2:0] size);
      case (size)
         SIZE_BYTE: return 64'h0000_0000_0000_00FF;
         SIZE_HALF: return 64'h0000_0000_0000_FFFF;
         SIZE_WORD: return 64'h0000_0000_FFFF_FFFF;
         default:   return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/simple_axi_ram_array.sv
// DEPTH_WORDS x 64-bit RAM, one byte-enabled write port and one registered read port.
// Split into byte lanes so each lane maps onto a plain block RAM.
module simple_axi_ram_array #(
   parameter int DEPTH_WORDS = 512,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [7:0]    wr_be,
   input  logic [63:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [63:0]   rd_data
);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] rd_lane_reg;

         // Read-before-write: a same-cycle read of the written word sees the old byte.
         always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
               mem[wr_idx] <= wr_data[gi*8 +: 8];
            end
            if (rd_en) begin
               rd_lane_reg <= mem[rd_idx];
            end
         end

         assign rd_data[gi*8 +: 8] = rd_lane_reg;
      end
   endgenerate

endmodule

// File: rtl/simple_axi_ram_slave.sv
// Single-beat AXI4 RAM slave with OKAY/SLVERR/DECERR decoding over a fixed window.
// Define SIMPLE_AXI_RAM_STALL_EN to add LFSR-driven ready gating and response delays.
module simple_axi_ram_slave
   import simple_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 512
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awsize,
   input  logic [7:0]  s_axi_awlen,
   input  logic [1:0]  s_axi_awburst,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [63:0] s_axi_wdata,
   input  logic [7:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic [1:0]  s_axi_bresp,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arsize,
   input  logic [7:0]  s_axi_arlen,
   input  logic [1:0]  s_axi_arburst,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast
);

   localparam int AW = $clog2(DEPTH_WORDS);

   function automatic resp_t check_req(input logic [31:0] addr, input logic [2:0] size,
                                       input logic [7:0] len, input logic [1:0] burst);
      logic [32:0] limit;
      limit = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd8;
      if (addr < BASE_ADDR || {1'b0, addr} >= limit) begin
         return RESP_DECERR;
      end else if (len != 8'd0 || burst != BURST_INCR || size > SIZE_DWORD ||
                   !addr_aligned(addr[2:0], size)) begin
         return RESP_SLVERR;
      end else begin
         return RESP_OKAY;
      end
   endfunction

   function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
      logic [31:0] offset;
      offset = addr - BASE_ADDR;
      return AW'(offset >> 3);
   endfunction

   logic ready_gate;
   logic resp_gate;

`ifdef SIMPLE_AXI_RAM_STALL_EN
   logic [7:0] lfsr_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_reg <= 8'hA5;
      end else begin
         lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      end
   end

   assign ready_gate = lfsr_reg[0];
   assign resp_gate  = lfsr_reg[1];
`else
   assign ready_gate = 1'b1;
   assign resp_gate  = 1'b1;
`endif

   // Keeps every ready low for the first cycle after reset even though the FSMs sit in IDLE.
   logic alive_reg;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) alive_reg <= 1'b0;
      else          alive_reg <= 1'b1;
   end

   logic unused_wlast;
   assign unused_wlast = s_axi_wlast;

   w_state_t    w_state_reg, w_state_next;
   logic        awready_int, wready_int;
   logic        aw_fire, w_fire, b_fire;
   logic [2:0]  w_off_reg;
   logic [AW-1:0] w_idx_reg;
   resp_t       w_resp_reg;
   resp_t       bresp_reg;
   logic        bvalid_reg;

   assign aw_fire = s_axi_awvalid && awready_int;
   assign w_fire  = s_axi_wvalid && wready_int;
   assign b_fire  = bvalid_reg && s_axi_bready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) w_state_reg <= W_IDLE;
      else          w_state_reg <= w_state_next;
   end

   always_comb begin
      w_state_next = w_state_reg;
      case (w_state_reg)
         W_IDLE:  if (aw_fire) w_state_next = W_DATA;
         W_DATA:  if (w_fire)  w_state_next = W_RESP;
         W_RESP:  if (b_fire)  w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   always_comb begin
      awready_int = alive_reg && ready_gate && (w_state_reg == W_IDLE);
      wready_int  = alive_reg && ready_gate && (w_state_reg == W_DATA);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         w_off_reg  <= '0;
         w_idx_reg  <= '0;
         w_resp_reg <= RESP_OKAY;
         bresp_reg  <= RESP_OKAY;
         bvalid_reg <= 1'b0;
      end else begin
         if (aw_fire) begin
            w_off_reg  <= s_axi_awaddr[2:0];
            w_idx_reg  <= word_index(s_axi_awaddr);
            w_resp_reg <= check_req(s_axi_awaddr, s_axi_awsize, s_axi_awlen, s_axi_awburst);
         end
         if (w_fire) begin
            bresp_reg  <= w_resp_reg;
            bvalid_reg <= resp_gate;
         end else if (w_state_reg == W_RESP && !bvalid_reg && resp_gate) begin
            bvalid_reg <= 1'b1;
         end else if (b_fire) begin
            bvalid_reg <= 1'b0;
         end
      end
   end

   logic          ram_wr_en;
   logic [63:0]   ram_wr_data;
   logic [7:0]    ram_wr_be;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_idx;
   logic [63:0]   ram_rd_data;

   assign ram_wr_en   = w_fire && (w_resp_reg == RESP_OKAY);
   assign ram_wr_data = s_axi_wdata << {w_off_reg, 3'b000};
   assign ram_wr_be   = s_axi_wstrb << w_off_reg;

   r_state_t    r_state_reg, r_state_next;
   logic        arready_int;
   logic        ar_fire, r_fire;
   logic [2:0]  r_off_reg;
   logic [2:0]  r_size_reg;
   resp_t       r_resp_reg;
   resp_t       rresp_reg;
   logic [63:0] rdata_reg;
   logic        rvalid_reg;
   logic        rlast_reg;

   assign ar_fire    = s_axi_arvalid && arready_int;
   assign r_fire     = rvalid_reg && s_axi_rready;
   assign ram_rd_en  = ar_fire;
   assign ram_rd_idx = word_index(s_axi_araddr);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state_reg <= R_IDLE;
      else          r_state_reg <= r_state_next;
   end

   always_comb begin
      r_state_next = r_state_reg;
      case (r_state_reg)
         R_IDLE:  if (ar_fire) r_state_next = R_READ;
         R_READ:  r_state_next = R_RESP;
         R_RESP:  if (r_fire) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready_int = alive_reg && ready_gate && (r_state_reg == R_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_off_reg  <= '0;
         r_size_reg <= '0;
         r_resp_reg <= RESP_OKAY;
         rresp_reg  <= RESP_OKAY;
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
         rlast_reg  <= 1'b0;
      end else begin
         if (ar_fire) begin
            r_off_reg  <= s_axi_araddr[2:0];
            r_size_reg <= s_axi_arsize;
            r_resp_reg <= check_req(s_axi_araddr, s_axi_arsize, s_axi_arlen, s_axi_arburst);
         end
         if (r_state_reg == R_READ) begin
            rdata_reg  <= (r_resp_reg == RESP_OKAY) ?
                          ((ram_rd_data >> {r_off_reg, 3'b000}) & size_mask(r_size_reg)) : 64'd0;
            rresp_reg  <= r_resp_reg;
            rvalid_reg <= resp_gate;
            rlast_reg  <= resp_gate;
         end else if (r_state_reg == R_RESP && !rvalid_reg && resp_gate) begin
            rvalid_reg <= 1'b1;
            rlast_reg  <= 1'b1;
         end else if (r_fire) begin
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
         end
      end
   end

   simple_axi_ram_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_ram (
      .clk    (i_clk),
      .wr_en  (ram_wr_en),
      .wr_idx (w_idx_reg),
      .wr_be  (ram_wr_be),
      .wr_data(ram_wr_data),
      .rd_en  (ram_rd_en),
      .rd_idx (ram_rd_idx),
      .rd_data(ram_rd_data)
   );

   assign s_axi_awready = awready_int;
   assign s_axi_wready  = wready_int;
   assign s_axi_bvalid  = bvalid_reg;
   assign s_axi_bresp   = bresp_reg;
   assign s_axi_arready = arready_int;
   assign s_axi_rvalid  = rvalid_reg;
   assign s_axi_rdata   = rdata_reg;
   assign s_axi_rresp   = rresp_reg;
   assign s_axi_rlast   = rlast_reg;

endmodule

// File: tb/tb_simple_axi_ram_slave.sv
// Directed bench for simple_axi_ram_slave; latency checks apply only when
// SIMPLE_AXI_RAM_STALL_EN is undefined.
`timescale 1ns/1ps
module tb_simple_axi_ram_slave;

   localparam int LIMIT = 300;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        s_axi_awvalid = 1'b0, s_axi_awready;
   logic [31:0] s_axi_awaddr = '0;
   logic [2:0]  s_axi_awsize = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [1:0]  s_axi_awburst = '0;
   logic        s_axi_wvalid = 1'b0, s_axi_wready;
   logic [63:0] s_axi_wdata = '0;
   logic [7:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_bvalid, s_axi_bready = 1'b0;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arvalid = 1'b0, s_axi_arready;
   logic [31:0] s_axi_araddr = '0;
   logic [2:0]  s_axi_arsize = '0;
   logic [7:0]  s_axi_arlen = '0;
   logic [1:0]  s_axi_arburst = '0;
   logic        s_axi_rvalid, s_axi_rready = 1'b0;
   logic [63:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;

   int vectors = 0;
   int miscompares = 0;

   always #5 i_clk = ~i_clk;

   simple_axi_ram_slave #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(512)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awsize(s_axi_awsize), .s_axi_awlen(s_axi_awlen), .s_axi_awburst(s_axi_awburst),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arsize(s_axi_arsize), .s_axi_arlen(s_axi_arlen), .s_axi_arburst(s_axi_arburst),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
   );

   // ---------------- channel drivers (no checking here) ----------------
   task automatic send_aw(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic [1:0] burst, output bit ok);
      int n = 0;
      s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awlen = len; s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      while (!s_axi_awready && n < LIMIT) begin @(posedge i_clk); #1; n++; end
      ok = (n < LIMIT);
      @(posedge i_clk); #1;
      s_axi_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] data, input logic [7:0] strb, output bit ok);
      int n = 0;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < LIMIT) begin @(posedge i_clk); #1; n++; end
      ok = (n < LIMIT);
      @(posedge i_clk); #1;
      s_axi_wvalid = 1'b0;
   endtask

   task automatic wait_b(output int lat, output bit ok);
      int n = 0;
      while (!s_axi_bvalid && n < LIMIT) begin @(posedge i_clk); #1; n++; end
      lat = n; ok = (n < LIMIT);
   endtask

   task automatic take_b(output logic [1:0] resp);
      resp = s_axi_bresp;
      s_axi_bready = 1'b1;
      @(posedge i_clk); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic [1:0] burst, output bit ok);
      int n = 0;
      s_axi_araddr = addr; s_axi_arsize = size; s_axi_arlen = len; s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      while (!s_axi_arready && n < LIMIT) begin @(posedge i_clk); #1; n++; end
      ok = (n < LIMIT);
      @(posedge i_clk); #1;
      s_axi_arvalid = 1'b0;
   endtask

   task automatic wait_r(output int lat, output bit ok);
      int n = 0;
      while (!s_axi_rvalid && n < LIMIT) begin @(posedge i_clk); #1; n++; end
      lat = n; ok = (n < LIMIT);
   endtask

   task automatic take_r(output logic [63:0] data, output logic [1:0] resp, output logic last);
      data = s_axi_rdata; resp = s_axi_rresp; last = s_axi_rlast;
      s_axi_rready = 1'b1;
      @(posedge i_clk); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic write_txn(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data,
                            input logic [7:0] strb, input logic [7:0] len, input logic [1:0] burst,
                            output logic [1:0] resp, output int lat, output bit ok);
      bit ok_aw, ok_w, ok_b;
      send_aw(addr, size, len, burst, ok_aw);
      send_w(data, strb, ok_w);
      wait_b(lat, ok_b);
      take_b(resp);
      ok = ok_aw && ok_w && ok_b;
      $display("WR addr=%h size=%0d len=%0d burst=%0d data=%h strb=%h -> bresp=%0d lat=%0d",
               addr, size, len, burst, data, strb, resp, lat);
   endtask

   task automatic read_txn(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [1:0] burst, output logic [63:0] data, output logic [1:0] resp,
                           output logic last, output int lat, output bit ok);
      bit ok_ar, ok_r;
      send_ar(addr, size, len, burst, ok_ar);
      wait_r(lat, ok_r);
      take_r(data, resp, last);
      ok = ok_ar && ok_r;
      $display("RD addr=%h size=%0d len=%0d burst=%0d -> rdata=%h rresp=%0d rlast=%0d lat=%0d",
               addr, size, len, burst, data, resp, last, lat);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [7:0] ctl;
      i_rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      ctl = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
             (s_axi_bresp != 2'd0), (s_axi_rresp != 2'd0)};
      vectors++;
      if (ctl !== 8'h00) begin
         miscompares++; $display("FAIL reset_ctl: got %b, expected 00000000", ctl);
      end
      vectors++;
      if (s_axi_rdata !== 64'd0) begin
         miscompares++; $display("FAIL reset_rdata: got %h, expected 0", s_axi_rdata);
      end
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
`ifndef SIMPLE_AXI_RAM_STALL_EN
      vectors++;
      if ({s_axi_awready, s_axi_arready, s_axi_wready} !== 3'b110) begin
         miscompares++;
         $display("FAIL reset_idle_ready: got aw/ar/w=%b, expected 110",
                  {s_axi_awready, s_axi_arready, s_axi_wready});
      end
`endif
      $display("reset sequence done");
   endtask

   task automatic test_dword();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok;
      write_txn(32'h8, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 8'd0, 2'b01, resp, lat, ok);
      vectors++;
      if (!ok || resp !== 2'd0) begin
         miscompares++; $display("FAIL dword_bresp: got resp=%0d ok=%0d, expected resp=0 ok=1", resp, ok);
      end
`ifndef SIMPLE_AXI_RAM_STALL_EN
      vectors++;
      if (lat != 0) begin
         miscompares++; $display("FAIL dword_b_latency: got %0d extra cycles, expected 0", lat);
      end
`endif
      read_txn(32'h8, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h1122_3344_5566_7788 || resp !== 2'd0 || last !== 1'b1) begin
         miscompares++;
         $display("FAIL dword_read: got data=%h resp=%0d last=%0d ok=%0d, expected 1122334455667788/0/1/1",
                  data, resp, last, ok);
      end
`ifndef SIMPLE_AXI_RAM_STALL_EN
      vectors++;
      if (lat != 1) begin
         miscompares++; $display("FAIL dword_r_latency: got rvalid at AR+%0d, expected AR+2", lat + 1);
      end
`endif
   endtask

   task automatic test_byte_merge();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok;
      write_txn(32'hB, 3'd0, 64'h0000_0000_0000_00AB, 8'h01, 8'd0, 2'b01, resp, lat, ok);
      vectors++;
      if (!ok || resp !== 2'd0) begin
         miscompares++; $display("FAIL byte_bresp: got %0d, expected 0", resp);
      end
      read_txn(32'h8, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h1122_3344_AB66_7788 || resp !== 2'd0) begin
         miscompares++; $display("FAIL byte_merge_dword: got %h resp=%0d, expected 11223344ab667788 resp=0", data, resp);
      end
      read_txn(32'hA, 3'd1, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h0000_0000_0000_AB66 || resp !== 2'd0) begin
         miscompares++; $display("FAIL half_read: got %h resp=%0d, expected 000000000000ab66 resp=0", data, resp);
      end
   endtask

   task automatic test_early_w();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok, ok_aw, ok_w;
      s_axi_wdata = 64'h5555_6666_7777_8888; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         vectors++;
         if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_w_ready: got wready=%b bvalid=%b, expected 0/0", s_axi_wready, s_axi_bvalid);
         end
      end
      send_aw(32'h20, 3'd3, 8'd0, 2'b01, ok_aw);
      send_w(64'h5555_6666_7777_8888, 8'hFF, ok_w);
      wait_b(lat, ok);
      take_b(resp);
      $display("WR addr=00000020 (early W) -> bresp=%0d", resp);
      vectors++;
      if (!(ok && ok_aw && ok_w) || resp !== 2'd0) begin
         miscompares++; $display("FAIL early_w_bresp: got %0d, expected 0", resp);
      end
      read_txn(32'h20, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h5555_6666_7777_8888) begin
         miscompares++; $display("FAIL early_w_data: got %h, expected 5555666677778888", data);
      end
   endtask

   task automatic test_decerr();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok;
      write_txn(32'h0, 3'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, 8'd0, 2'b01, resp, lat, ok);
      write_txn(32'h1000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 2'b01, resp, lat, ok);
      vectors++;
      if (!ok || resp !== 2'd3) begin
         miscompares++; $display("FAIL decerr_bresp: got %0d, expected 3", resp);
      end
      read_txn(32'h0, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'hDEAD_BEEF_0123_4567 || resp !== 2'd0) begin
         miscompares++; $display("FAIL decerr_ram_unchanged: got %h resp=%0d, expected deadbeef01234567 resp=0", data, resp);
      end
   endtask

   // Request-check table: {addr, size, len, burst, expected resp}
   logic [31:0] chk_addr  [9] = '{32'h1000, 32'hFFFF_FFF8, 32'h8, 32'h8, 32'h8, 32'h9, 32'hA, 32'hC, 32'h1000};
   logic [2:0]  chk_size  [9] = '{3'd3, 3'd3, 3'd4, 3'd3, 3'd3, 3'd1, 3'd2, 3'd3, 3'd3};
   logic [7:0]  chk_len   [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
   logic [1:0]  chk_burst [9] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
   logic [1:0]  chk_resp  [9] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};

   task automatic test_slverr();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok;
      write_txn(32'h2, 3'd2, 64'hFFFF_FFFF, 8'h0F, 8'd0, 2'b01, resp, lat, ok);
      vectors++;
      if (!ok || resp !== 2'd2) begin
         miscompares++; $display("FAIL slverr_misaligned_bresp: got %0d, expected 2", resp);
      end
      read_txn(32'h0, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'hDEAD_BEEF_0123_4567) begin
         miscompares++; $display("FAIL slverr_ram_unchanged: got %h, expected deadbeef01234567", data);
      end
      read_txn(32'h8, 3'd3, 8'd1, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || resp !== 2'd2 || data !== 64'd0 || last !== 1'b1) begin
         miscompares++; $display("FAIL slverr_arlen: got resp=%0d data=%h last=%0d, expected 2/0/1", resp, data, last);
      end
      for (int i = 0; i < 9; i++) begin
         write_txn(chk_addr[i], chk_size[i], 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, chk_len[i], chk_burst[i], resp, lat, ok);
         vectors++;
         if (!ok || resp !== chk_resp[i]) begin
            miscompares++; $display("FAIL check_w[%0d]: got bresp=%0d, expected %0d", i, resp, chk_resp[i]);
         end
         read_txn(chk_addr[i], chk_size[i], chk_len[i], chk_burst[i], data, resp, last, lat, ok);
         vectors++;
         if (!ok || resp !== chk_resp[i] || data !== 64'd0) begin
            miscompares++; $display("FAIL check_r[%0d]: got rresp=%0d data=%h, expected %0d/0", i, resp, data, chk_resp[i]);
         end
      end
      read_txn(32'h8, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h1122_3344_AB66_7788) begin
         miscompares++; $display("FAIL check_ram_unchanged: got %h, expected 11223344ab667788", data);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok, ok2;
      send_aw(32'h10, 3'd3, 8'd0, 2'b01, ok);
      send_w(64'h0102_0304_0506_0708, 8'hFF, ok2);
      wait_b(lat, ok);
      s_axi_awaddr = 32'h18; s_axi_awsize = 3'd3; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
      s_axi_awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk); #1;
         vectors++;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'd0 || s_axi_awready !== 1'b0) begin
            miscompares++;
            $display("FAIL b_hold[%0d]: got bvalid=%b bresp=%0d awready=%b, expected 1/0/0",
                     i, s_axi_bvalid, s_axi_bresp, s_axi_awready);
         end
      end
      take_b(resp);
      $display("WR addr=00000010 (bready held) -> bresp=%0d", resp);
`ifndef SIMPLE_AXI_RAM_STALL_EN
      vectors++;
      if (s_axi_awready !== 1'b1) begin
         miscompares++; $display("FAIL aw_after_b: got awready=%b, expected 1", s_axi_awready);
      end
`endif
      send_aw(32'h18, 3'd3, 8'd0, 2'b01, ok);
      send_w(64'h0A0B_0C0D_0E0F_1011, 8'hFF, ok2);
      wait_b(lat, ok);
      take_b(resp);
      $display("WR addr=00000018 -> bresp=%0d", resp);
      send_ar(32'h10, 3'd3, 8'd0, 2'b01, ok);
      wait_r(lat, ok2);
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk); #1;
         vectors++;
         if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 64'h0102_0304_0506_0708 ||
             s_axi_rresp !== 2'd0 || s_axi_rlast !== 1'b1) begin
            miscompares++;
            $display("FAIL r_hold[%0d]: got rvalid=%b rdata=%h rresp=%0d rlast=%b, expected 1/0102030405060708/0/1",
                     i, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast);
         end
      end
      take_r(data, resp, last);
      $display("RD addr=00000010 (rready held) -> rdata=%h rresp=%0d", data, resp);
      read_txn(32'h18, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h0A0B_0C0D_0E0F_1011) begin
         miscompares++; $display("FAIL b2b_second_write: got %h, expected 0a0b0c0d0e0f1011", data);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok;
      logic [7:0] ctl;
      send_aw(32'h10, 3'd3, 8'd0, 2'b01, ok);
      s_axi_wdata = 64'hFFFF_0000_FFFF_0000; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
      #1;
      i_rst_n = 1'b0;
      #1;
      ctl = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
             (s_axi_bresp != 2'd0), (s_axi_rresp != 2'd0)};
      vectors++;
      if (ctl !== 8'h00 || s_axi_rdata !== 64'd0) begin
         miscompares++; $display("FAIL midreset_outputs: got ctl=%b rdata=%h, expected 0/0", ctl, s_axi_rdata);
      end
      $display("reset asserted in W_DATA");
      @(posedge i_clk); #1;
      s_axi_wvalid = 1'b0;
      i_rst_n = 1'b1;
      read_txn(32'h10, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h0102_0304_0506_0708) begin
         miscompares++; $display("FAIL midreset_ram_unchanged: got %h, expected 0102030405060708", data);
      end
      write_txn(32'h10, 3'd3, 64'hCAFE_F00D_1234_5678, 8'hFF, 8'd0, 2'b01, resp, lat, ok);
      read_txn(32'h10, 3'd3, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'hCAFE_F00D_1234_5678 || resp !== 2'd0) begin
         miscompares++; $display("FAIL midreset_next_write: got %h resp=%0d, expected cafef00d12345678 resp=0", data, resp);
      end
   endtask

   task automatic test_boundary();
      logic [1:0] resp; logic [63:0] data; logic last; int lat; bit ok;
      write_txn(32'hFF8, 3'd3, 64'h8877_6655_4433_2211, 8'hFF, 8'd0, 2'b01, resp, lat, ok);
      vectors++;
      if (!ok || resp !== 2'd0) begin
         miscompares++; $display("FAIL last_word_bresp: got %0d, expected 0", resp);
      end
      read_txn(32'hFFC, 3'd2, 8'd0, 2'b01, data, resp, last, lat, ok);
      vectors++;
      if (!ok || data !== 64'h0000_0000_8877_6655 || resp !== 2'd0) begin
         miscompares++; $display("FAIL last_word_upper: got %h resp=%0d, expected 0000000088776655 resp=0", data, resp);
      end
   endtask

   initial begin
      test_reset();
      test_dword();
      test_byte_merge();
      test_early_w();
      test_decerr();
      test_slverr();
      test_backpressure();
      test_reset_mid();
      test_boundary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
